// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: parses W/R frames from the RX FIFO, runs them on a small register file
// and pushes one response byte per frame to the TX FIFO. Optional macro CMD_ECHO_EN echoes the
// command byte ahead of the response.
module uart_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_REGS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_empty_i,
    output logic                  rx_ren_o,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  tx_full_i,
    output logic                  tx_wen_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic [3:0]            led_o,
    output logic                  busy_o,
    output logic [7:0]            err_cnt_o
);

    localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

    localparam logic [TmoW-1:0]       TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] NumRegsB = DATA_WIDTH'(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ChW      = DATA_WIDTH'(8'h57);
    localparam logic [DATA_WIDTH-1:0] ChR      = DATA_WIDTH'(8'h52);
    localparam logic [DATA_WIDTH-1:0] ChK      = DATA_WIDTH'(8'h4B);
    localparam logic [DATA_WIDTH-1:0] ChE      = DATA_WIDTH'(8'h45);
    localparam logic [DATA_WIDTH-1:0] ChQ      = DATA_WIDTH'(8'h3F);

    typedef enum logic [2:0] {
        StCmd, StCmdWait, StAddr, StAddrWait, StData, StDataWait, StExec, StResp
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic [7:0]            err_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  err_inc;
    logic                  reg_we;
    logic                  addr_ok;
    logic [DATA_WIDTH-1:0] rd_data;
`ifdef CMD_ECHO_EN
    logic                  echo_q, echo_d;
`endif

    // Full 8-bit compare; only in-range addresses ever reach the index mux.
    assign addr_ok = (addr_q < NumRegsB);
    assign rd_data = regs_q[addr_q[IdxW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StCmd;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        resp_d  = resp_q;
        tmo_d   = tmo_q;
        err_inc = 1'b0;
        reg_we  = 1'b0;
`ifdef CMD_ECHO_EN
        echo_d  = echo_q;
`endif
        unique case (state_q)
            StCmd: begin
                tmo_d = '0;
                if (!rx_empty_i) begin
                    state_d = StCmdWait;
                end
            end
            StCmdWait: begin
                cmd_d = rx_data_i;
                if (rx_data_i == ChW || rx_data_i == ChR) begin
                    state_d = StAddr;
                end else begin
                    resp_d  = ChQ;
                    err_inc = 1'b1;
                    state_d = StResp;
                end
            end
            StAddr, StData: begin
                if (!rx_empty_i) begin
                    tmo_d   = '0;
                    state_d = (state_q == StAddr) ? StAddrWait : StDataWait;
                end else if (tmo_q == TmoLast) begin
                    // Abort silently: no response, registers untouched.
                    tmo_d   = '0;
                    err_inc = 1'b1;
                    state_d = StCmd;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StAddrWait: begin
                addr_d  = rx_data_i;
                state_d = (cmd_q == ChW) ? StData : StExec;
            end
            StDataWait: begin
                data_d  = rx_data_i;
                state_d = StExec;
            end
            StExec: begin
                if (!addr_ok) begin
                    resp_d  = ChE;
                    err_inc = 1'b1;
                end else if (cmd_q == ChW) begin
                    reg_we = 1'b1;
                    resp_d = ChK;
                end else begin
                    resp_d = rd_data;
                end
                state_d = StResp;
            end
            StResp: begin
                if (!tx_full_i) begin
`ifdef CMD_ECHO_EN
                    echo_d = ~echo_q;
                    if (echo_q) begin
                        state_d = StCmd;
                    end
`else
                    state_d = StCmd;
`endif
                end
            end
            default: state_d = StCmd;
        endcase
    end

    always_comb begin
        rx_ren_o = 1'b0;
        tx_wen_o = 1'b0;
`ifdef CMD_ECHO_EN
        tx_data_o = echo_q ? resp_q : cmd_q;
`else
        tx_data_o = resp_q;
`endif
        unique case (state_q)
            StCmd, StAddr, StData: rx_ren_o = !rx_empty_i;
            StResp:                tx_wen_o = !tx_full_i;
            default:               ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            resp_q <= '0;
            tmo_q  <= '0;
            err_q  <= '0;
`ifdef CMD_ECHO_EN
            echo_q <= 1'b0;
`endif
        end else begin
            cmd_q  <= cmd_d;
            addr_q <= addr_d;
            data_q <= data_d;
            resp_q <= resp_d;
            tmo_q  <= tmo_d;
            if (err_inc && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
`ifdef CMD_ECHO_EN
            echo_q <= echo_d;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[addr_q[IdxW-1:0]] <= data_q;
        end
    end

    assign led_o     = regs_q[0][3:0];
    assign busy_o    = (state_q != StCmd);
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: modelled RX FIFO, expected TX bytes queued on stimulus and
// popped when the controller writes the TX FIFO.
module tb_uart_cmd_ctrl;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_empty;
    logic       rx_ren;
    logic [7:0] rx_data = 8'h00;
    logic       tx_full;
    logic       tx_wen;
    logic [7:0] tx_data;
    logic [3:0] led;
    logic       busy;
    logic [7:0] err_cnt;

    uart_cmd_ctrl #(
        .DATA_WIDTH    (8),
        .NUM_REGS      (4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .rx_empty_i(rx_empty),
        .rx_ren_o  (rx_ren),
        .rx_data_i (rx_data),
        .tx_full_i (tx_full),
        .tx_wen_o  (tx_wen),
        .tx_data_o (tx_data),
        .led_o     (led),
        .busy_o    (busy),
        .err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    // RX FIFO model: data appears the cycle after a read pulse.
    logic [7:0] rx_mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign rx_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rx_ren) begin
            rx_data <= rx_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 8'd1;
        end
    end

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    int         cyc = 0;
    int         wen_cnt = 0;
    int         ren_cnt = 0;
    int         ren_mark = -1;
    int         wen_cyc = 0;
    logic [7:0] wen_data = 8'h00;
    logic [3:0] wen_led = 4'h0;
    logic [3:0] led_prev = 4'h0;
    logic [3:0] led_pre_wen = 4'h0;
    logic       s_busy = 1'b0;
    logic [7:0] s_err = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge, then return just after the next rising edge to drive.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rx_ren) begin
            ren_cnt++;
            if (ren_mark < 0) ren_mark = cyc;
        end
        if (tx_wen) begin
            wen_cnt++;
            wen_cyc     = cyc;
            wen_data    = tx_data;
            wen_led     = led;
            led_pre_wen = led_prev;
        end
        led_prev = led;
        s_busy   = busy;
        s_err    = err_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[wr_ptr] = b;
        wr_ptr         = wr_ptr + 8'd1;
    endtask

    task automatic await_resp(input string tag, input int lat);
        int         w0;
        logic [7:0] e;
        w0 = wen_cnt;
        for (int i = 0; i < 400; i++) begin
            if (wen_cnt != w0) break;
            tick();
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, " pulse"}, 32'(wen_cnt != w0), 32'd1);
        check({tag, " data"}, 32'(wen_data), 32'(e));
        if (lat >= 0) check({tag, " latency"}, wen_cyc - ren_mark, lat);
    endtask

    task automatic frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int nb, input logic [7:0] resp,
                         input int lat);
        int w0, r0;
        w0       = wen_cnt;
        r0       = ren_cnt;
        ren_mark = -1;
        push(b0);
        if (nb > 1) push(b1);
        if (nb > 2) push(b2);
        exp_q.push_back(resp);
        await_resp(tag, lat);
        tick();
        tick();
        check({tag, " pulses"}, wen_cnt - w0, 1);
        check({tag, " reads"}, ren_cnt - r0, nb);
        check({tag, " idle"}, 32'(s_busy), 32'd0);
    endtask

    initial begin
        int w0, r1;
        rst_n   = 1'b0;
        tx_full = 1'b0;
        #2;
        check("rst tx_wen", 32'(tx_wen), 32'd0);
        check("rst rx_ren", 32'(rx_ren), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst led", 32'(led), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Write reg0 = 0x0A, then read back.
        frame("wr0", 8'h57, 8'h00, 8'h0A, 3, 8'h4B, 7);
        check("wr0 led before", 32'(led_pre_wen), 32'h0);
        check("wr0 led after", 32'(wen_led), 32'hA);
        check("wr0 err", 32'(s_err), 32'd0);
        frame("rd0", 8'h52, 8'h00, 8'h00, 2, 8'h0A, 5);
        frame("rd3", 8'h52, 8'h03, 8'h00, 2, 8'h00, 5);

        // Bad address and unknown command.
        frame("wr7", 8'h57, 8'h07, 8'h55, 3, 8'h45, 7);
        check("wr7 err", 32'(s_err), 32'd1);
        check("wr7 led", 32'(led_prev), 32'hA);
        frame("rd3 post", 8'h52, 8'h03, 8'h00, 2, 8'h00, 5);
        frame("rd83", 8'h52, 8'h83, 8'h00, 2, 8'h45, 5);
        check("rd83 err", 32'(s_err), 32'd2);
        frame("unk", 8'h41, 8'h00, 8'h00, 1, 8'h3F, 2);
        check("unk err", 32'(s_err), 32'd3);

        // Timeout after a lone 'W'.
        w0       = wen_cnt;
        ren_mark = -1;
        push(8'h57);
        for (int i = 0; i < 10 && ren_mark < 0; i++) tick();
        for (int i = 0; i < TMO + 1; i++) tick();
        check("tmo busy last", 32'(s_busy), 32'd1);
        tick();
        check("tmo busy drop", 32'(s_busy), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("tmo no tx", wen_cnt - w0, 0);
        check("tmo err", 32'(s_err), 32'd4);
        check("tmo led", 32'(led_prev), 32'hA);
        frame("tmo rd0", 8'h52, 8'h00, 8'h00, 2, 8'h0A, 5);

        // TX backpressure during a read response; queued bytes must wait.
        tx_full  = 1'b1;
        w0       = wen_cnt;
        ren_mark = -1;
        push(8'h52);
        push(8'h00);
        exp_q.push_back(8'h0A);
        for (int i = 0; i < 10 && ren_mark < 0; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        push(8'h52);
        push(8'h01);
        exp_q.push_back(8'h00);
        r1 = ren_cnt;
        for (int i = 0; i < 20; i++) tick();
        check("bp no tx", wen_cnt - w0, 0);
        check("bp no rx", ren_cnt - r1, 0);
        tx_full = 1'b0;
        tick();
        check("bp release", wen_cnt - w0, 1);
        check("bp release cyc", wen_cyc, cyc);
        check("bp data", 32'(wen_data), 32'(exp_q.pop_front()));
        ren_mark = -1;
        await_resp("bp rd1", 5);

        // Async reset in the middle of a write frame.
        frame("wr1", 8'h57, 8'h01, 8'h33, 3, 8'h4B, 7);
        frame("rd1", 8'h52, 8'h01, 8'h00, 2, 8'h33, 5);
        r1 = ren_cnt;
        push(8'h57);
        push(8'h01);
        for (int i = 0; i < 20 && ren_cnt - r1 < 2; i++) tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid rst tx_wen", 32'(tx_wen), 32'd0);
        check("mid rst tx_data", 32'(tx_data), 32'd0);
        check("mid rst led", 32'(led), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst err", 32'(err_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        frame("post rd1", 8'h52, 8'h01, 8'h00, 2, 8'h00, 5);
        frame("post rd0", 8'h52, 8'h00, 8'h00, 2, 8'h00, 5);

        // Error counter saturation.
        for (int k = 0; k < 260; k++) frame("sat", 8'h3A, 8'h00, 8'h00, 1, 8'h3F, 2);
        check("sat err", 32'(s_err), 32'hFF);
        frame("sat wr", 8'h57, 8'h00, 8'h05, 3, 8'h4B, 7);
        check("sat led", 32'(wen_led), 32'h5);
        check("sat err hold", 32'(s_err), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
